// File: rtl/mtm_alu_frame_serializer.sv
// mtm_alu_frame_serializer
// Takes one ALU result word and its control byte over a valid/ready handshake.
// Sends them on sout as 11-bit packets: start 0, type bit, 8 payload bits MSB
// first, stop 1. A data frame is DATA_BYTES data packets followed by one
// control packet. A legal error frame is a single control packet. An illegal
// error byte is accepted, then discarded with a one-cycle drop pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle-high, ready for the next result
// START | start bit (0) of the current packet
// TYPE  | type bit: 1 on the final (control) packet, else 0
// DATA  | 8 payload bits, MSB first, bit_cnt_q indexes the bit
// STOP  | stop bit (1); then the next packet or back to IDLE
module mtm_alu_frame_serializer #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned BIT_DIV    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [7:0]              in_ctl,
    output logic                    sout,
    output logic                    busy,
    output logic                    drop
);

    localparam int unsigned DW = 8 * DATA_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  data_q;
    logic [7:0]     ctl_q;
    logic [3:0]     pkt_cnt_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     div_q;
    logic           sout_q;
    logic           drop_q;

    logic           last_pkt_d;
    logic [7:0]     payload_d;
    logic [2:0]     bit_nxt_d;
    logic           div_last_d;
    logic           legal_err_d;
    logic           xfer_d;

    // The top data byte is always the one in flight: data_q shifts left by a
    // byte after each data packet, so no computed byte index is needed.
    assign last_pkt_d  = (pkt_cnt_q == 4'd1);
    assign payload_d   = last_pkt_d ? ctl_q : data_q[DW-1 -: 8];
    assign bit_nxt_d   = bit_cnt_q + 3'd1;
    assign div_last_d  = (div_q == 8'(BIT_DIV - 1));
    assign legal_err_d = (in_ctl == 8'hC9) || (in_ctl == 8'h93) || (in_ctl == 8'hA5);
    assign xfer_d      = in_valid && in_ready;

    assign in_ready = (state_q == S_IDLE) && !rst;
    assign busy     = (state_q != S_IDLE);
    assign sout     = sout_q;
    assign drop     = drop_q;

    // Frame sequencer; sout_q is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            ctl_q     <= 8'h00;
            pkt_cnt_q <= 4'd0;
            bit_cnt_q <= 3'd0;
            div_q     <= 8'd0;
            sout_q    <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (state_q == S_IDLE) begin
                sout_q    <= 1'b1;
                div_q     <= 8'd0;
                bit_cnt_q <= 3'd0;
                if (xfer_d) begin
                    data_q <= in_data;
                    ctl_q  <= in_ctl;
                    if (!in_ctl[7]) begin
                        pkt_cnt_q <= 4'(DATA_BYTES + 1);
                        state_q   <= S_START;
                        sout_q    <= 1'b0;
                    end else if (legal_err_d) begin
                        pkt_cnt_q <= 4'd1;
                        state_q   <= S_START;
                        sout_q    <= 1'b0;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
            end else if (!div_last_d) begin
                div_q <= div_q + 8'd1;
            end else begin
                div_q <= 8'd0;
                case (state_q)
                    S_START: begin
                        state_q <= S_TYPE;
                        sout_q  <= last_pkt_d;
                    end
                    S_TYPE: begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= 3'd0;
                        sout_q    <= payload_d[7];
                    end
                    S_DATA: begin
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                            sout_q  <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_nxt_d;
                            // 7 - (k+1) on a 3-bit index is its bitwise inverse
                            sout_q    <= payload_d[~bit_nxt_d];
                        end
                    end
                    S_STOP: begin
                        pkt_cnt_q <= pkt_cnt_q - 4'd1;
                        if (last_pkt_d) begin
                            state_q <= S_IDLE;
                            sout_q  <= 1'b1;
                        end else begin
                            state_q <= S_START;
                            sout_q  <= 1'b0;
                            data_q  <= data_q << 8;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        sout_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_frame_serializer.sv
// Bench for mtm_alu_frame_serializer: instance 0 uses DATA_BYTES=4/BIT_DIV=1,
// instance 1 uses DATA_BYTES=2/BIT_DIV=4. Expected sout waveforms come from a
// packet-list model that expands each 11-bit packet into BIT_DIV samples.
module tb_mtm_alu_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic        rdy0, rdy1;
    logic [31:0] in_data0;
    logic [15:0] in_data1;
    logic [7:0]  ctl0, ctl1;
    logic        sout0, sout1, busy0, busy1, drop0, drop1;

    int tests = 0;
    int fails = 0;
    bit exp_q[$];
    bit exp_drop;

    typedef struct {
        int          idx;
        logic [63:0] d;
        logic [7:0]  c;
        int          cycles;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    mtm_alu_frame_serializer #(.DATA_BYTES(4), .BIT_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(in_data0),
        .in_ctl(ctl0), .sout(sout0), .busy(busy0), .drop(drop0)
    );

    mtm_alu_frame_serializer #(.DATA_BYTES(2), .BIT_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(in_data1),
        .in_ctl(ctl1), .sout(sout1), .busy(busy1), .drop(drop1)
    );

    function automatic int db_of(input int idx);
        return (idx == 0) ? 4 : 2;
    endfunction

    function automatic int bd_of(input int idx);
        return (idx == 0) ? 1 : 4;
    endfunction

    function automatic logic f_sout(input int idx);
        return (idx == 0) ? sout0 : sout1;
    endfunction

    function automatic logic f_busy(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction

    function automatic logic f_rdy(input int idx);
        return (idx == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic f_drop(input int idx);
        return (idx == 0) ? drop0 : drop1;
    endfunction

    task automatic set_in(input int idx, input logic v, input logic [63:0] d, input logic [7:0] c);
        if (idx == 0) begin
            v0 = v; in_data0 = d[31:0]; ctl0 = c;
        end else begin
            v1 = v; in_data1 = d[15:0]; ctl1 = c;
        end
    endtask

    function automatic void push_packet(input bit typ, input logic [7:0] b, input int bd);
        bit [10:0] pk;
        pk = {1'b0, typ, b, 1'b1};
        for (int i = 10; i >= 0; i--)
            for (int r = 0; r < bd; r++)
                exp_q.push_back(pk[i]);
    endfunction

    function automatic void model_frame(input int db, input int bd, input logic [63:0] d, input logic [7:0] c);
        exp_drop = 1'b0;
        if (!c[7]) begin
            for (int b = db - 1; b >= 0; b--)
                push_packet(1'b0, d[8*b +: 8], bd);
            push_packet(1'b1, c, bd);
        end else if (c == 8'hC9 || c == 8'h93 || c == 8'hA5) begin
            push_packet(1'b1, c, bd);
        end else begin
            exp_drop = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits a bounded number of cycles for in_ready.
    task automatic wait_ready(input int idx, input string name);
        int g = 0;
        while (!f_rdy(idx) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("%s ready", name), 64'(f_rdy(idx)), 64'd1);
    endtask

    task automatic run_frame(input int idx, input logic [63:0] d, input logic [7:0] c,
                             input int exp_cycles, input string name);
        int n, bad, busy_cnt, g, cyc;
        exp_q.delete();
        model_frame(db_of(idx), bd_of(idx), d, c);
        n = exp_q.size();
        cyc = (exp_cycles < 0) ? n : exp_cycles;
        bad = 0;
        busy_cnt = 0;
        @(negedge clk);
        wait_ready(idx, name);
        set_in(idx, 1'b1, d, c);
        @(posedge clk);
        @(negedge clk);
        set_in(idx, 1'b0, 64'h0, 8'h00);
        if (exp_drop) begin
            chk($sformatf("%s drop pulse", name),
                {60'd0, f_drop(idx), f_busy(idx), f_rdy(idx), f_sout(idx)}, 64'hB);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (f_drop(idx) || f_busy(idx) || !f_sout(idx)) bad++;
            end
            chk($sformatf("%s drop quiet", name), 64'(bad), 64'(cyc));
        end else begin
            for (int k = 0; k < n; k++) begin
                if (k > 0) @(negedge clk);
                if (f_sout(idx) !== exp_q[k]) bad++;
                if (f_busy(idx)) busy_cnt++;
            end
            @(negedge clk);
            g = 0;
            while (f_busy(idx) && g < 400) begin
                busy_cnt++;
                g++;
                @(negedge clk);
            end
            chk($sformatf("%s sout seq", name), 64'(bad), 64'd0);
            chk($sformatf("%s busy cycles", name), 64'(busy_cnt), 64'(cyc));
            chk($sformatf("%s end idle", name),
                {61'd0, f_sout(idx), f_rdy(idx), f_busy(idx)}, 64'h6);
        end
    endtask

    task automatic back_to_back();
        bit exp_all[$];
        int na, bad, rdy_cnt;
        exp_q.delete();
        model_frame(4, 1, 64'hDEADBEEF, 8'h05);
        na = exp_q.size();
        exp_q.push_back(1'b1);
        model_frame(4, 1, 64'hCAFEF00D, 8'h11);
        exp_all = exp_q;
        bad = 0;
        rdy_cnt = 0;
        @(negedge clk);
        wait_ready(0, "b2b");
        set_in(0, 1'b1, 64'hDEADBEEF, 8'h05);
        @(posedge clk);
        for (int k = 0; k < exp_all.size(); k++) begin
            @(negedge clk);
            if (k == 0) set_in(0, 1'b1, 64'hCAFEF00D, 8'h11);
            if (k == na + 1) set_in(0, 1'b0, 64'h0, 8'h00);
            if (sout0 !== exp_all[k]) bad++;
            if (rdy0) rdy_cnt++;
        end
        chk("b2b sout seq", 64'(bad), 64'd0);
        chk("b2b idle gap", 64'(rdy_cnt), 64'd1);
        @(negedge clk);
        chk("b2b end idle", {61'd0, sout0, rdy0, busy0}, 64'h6);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        wait_ready(0, "rstmid");
        set_in(0, 1'b1, 64'h0F0F0F0F, 8'h22);
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) set_in(0, 1'b0, 64'h0, 8'h00);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid abort", {61'd0, sout0, busy0, rdy0}, 64'h4);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready after", {62'd0, rdy0, sout0}, 64'h3);
        run_frame(0, 64'h13579BDF, 8'h3C, 55, "rstmid next");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        int          idx;
        int          sel;

        vecs[0] = '{0, 64'h12345678, 8'h0B, 55};
        vecs[1] = '{0, 64'hFFFFFFFF, 8'hC9, 11};
        vecs[2] = '{0, 64'h11111111, 8'h80, 0};
        vecs[3] = '{1, 64'h0000A55A, 8'h01, 132};
        vecs[4] = '{1, 64'h00001234, 8'h93, 44};
        vecs[5] = '{1, 64'h00000000, 8'hA5, 44};
        vecs[6] = '{0, 64'h00000000, 8'hFF, 0};
        vecs[7] = '{1, 64'h000000FF, 8'h7F, 132};
        vecs[8] = '{0, 64'h89ABCDEF, 8'h93, 11};

        rst = 1'b1;
        set_in(0, 1'b0, 64'h0, 8'h00);
        set_in(1, 1'b0, 64'h0, 8'h00);
        repeat (3) @(negedge clk);
        chk("reset dut0", {60'd0, rdy0, sout0, busy0, drop0}, 64'h4);
        chk("reset dut1", {60'd0, rdy1, sout1, busy1, drop1}, 64'h4);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", {62'd0, rdy0, rdy1}, 64'h3);

        for (int i = 0; i < 9; i++)
            run_frame(vecs[i].idx, vecs[i].d, vecs[i].c, vecs[i].cycles, $sformatf("vec%0d", i));

        back_to_back();
        reset_mid_frame();

        for (int i = 0; i < 24; i++) begin
            idx = int'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1: c = {1'b0, 7'($urandom)};
                2: begin
                    case ($urandom_range(0, 2))
                        0: c = 8'hC9;
                        1: c = 8'h93;
                        default: c = 8'hA5;
                    endcase
                end
                default: c = {1'b1, 7'($urandom)};
            endcase
            run_frame(idx, d, c, -1, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mtm_alu_frame_serializer.md
# mtm_alu_frame_serializer

Parametrised UART-style frame serializer for the MTM ALU result path. It accepts one result word plus its control byte over a valid/ready handshake. It emits the result on a single serial line as a sequence of 11-bit packets, with a configurable payload width and bit period. It sits between the ALU core and the `sout` pin and replaces the fixed 32-bit, one-bit-per-clock serializer.

## Interface

Parameters:
- `DATA_BYTES`, default 4: number of data bytes in a result frame, range 1..8.
- `BIT_DIV`, default 1: clock cycles per serial bit, range 1..255.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: `in_data`/`in_ctl` hold a result.
- `in_ready`, out, 1: block can accept a result this cycle.
- `in_data`, in, 8*DATA_BYTES: result word; the MSB byte is sent first.
- `in_ctl`, in, 8: control byte. Bit 7 = 0 means a data frame; bit 7 = 1 means an error frame.
- `sout`, out, 1: serial output; idle level is 1.
- `busy`, out, 1: a frame is in progress.
- `drop`, out, 1: one-cycle pulse when an accepted error control byte is illegal and is discarded.

## Operation

- Handshake:
  - Transfer occurs on a rising edge with `in_valid && in_ready`.
  - `in_data` and `in_ctl` are latched internally at the transfer.
  - Inputs are ignored at all other times.
- Packet format, 11 bits, sent in order:
  - Start bit 0.
  - Type bit: 0 = data byte, 1 = control byte.
  - 8 payload bits, MSB first.
  - Stop bit 1.
- Data frame (`in_ctl[7]`=0): DATA_BYTES data packets, byte DATA_BYTES-1 down to byte 0, then one control packet carrying `in_ctl`.
- Error frame: `in_ctl` ∈ {0xC9, 0x93, 0xA5} sends a single control packet carrying `in_ctl`.
- Any other `in_ctl` with bit 7 = 1:
  - Accepted but not sent; `drop` pulses in the cycle after the transfer.
  - `sout` stays 1.
  - `in_ready` is high again on that same cycle.
- FSM states: IDLE, START, TYPE, DATA, STOP.
  - IDLE → START on a transfer of a sendable frame.
  - START → TYPE → DATA.
  - DATA stays for 8 bits, indexed by a 3-bit bit counter, then → STOP.
  - STOP → START if packets remain, else → IDLE.
- Counters:
  - The packet counter is loaded with DATA_BYTES+1 (data frame) or 1 (error frame) and decremented at each STOP exit.
  - The type bit is 1 when the packet counter equals 1.
  - A divider counter 0..BIT_DIV-1 gates every state advance outside IDLE.
- `sout` is registered. It is 1 in IDLE, then 0 / type / payload bit / 1 in START / TYPE / DATA / STOP respectively.
- `in_ready` = (state == IDLE) && !rst.
- `busy` = state != IDLE.

## Timing

- Reset values: `sout`=1, `in_ready`=0 while `rst` is high, `busy`=0, `drop`=0, state IDLE, all counters 0.
- `in_ready` is 1 in the first cycle after `rst` deasserts.
- Latency: the start bit appears on `sout` in the cycle after the transfer edge.
- Each bit is held exactly BIT_DIV cycles.
- Frame duration:
  - Data frame: (DATA_BYTES+1)·11·BIT_DIV cycles.
  - Error frame: 11·BIT_DIV cycles.
- Between packets of one frame there is no idle gap: a stop bit is followed directly by the next start bit.
- Back-to-back frames:
  - After the last stop bit the FSM spends at least one IDLE cycle (`sout`=1, `in_ready`=1).
  - The minimum inter-frame gap is therefore 1 clock.
- `in_valid` held while `in_ready`=0 has no effect, and the data is not sampled.
- `rst` asserted mid-frame:
  - The frame is aborted.
  - On the next edge, `sout`=1 and state is IDLE.
  - No partial packet resumes.
- The data-frame ordering and counters are parameter-independent. Reaching the last bit is detected by comparing against the constant 7, never by a computed index.

## Test plan

- Data frame, DATA_BYTES=4, BIT_DIV=1, `in_data`=0x12345678, `in_ctl`=0x0B.
  - `sout` over 55 cycles = packets 0 0 00010010 1 | …0x34… | …0x56… | …0x78… | 0 1 00001011 1.
  - `busy` is high for exactly 55 cycles.
  - `in_ready` returns on cycle 56.
- Error frame, `in_ctl`=0xC9 → exactly 11 bits 0 1 11001001 1, then IDLE.
- Illegal error byte, `in_ctl`=0x80 → `drop`=1 for one cycle, `sout` constantly 1, `busy` never set.
- Timing parameters, BIT_DIV=4 and DATA_BYTES=2, `in_data`=0xA55A, `in_ctl`=0x01 → each bit lasts 4 cycles, and the frame lasts 132 cycles.
- Back-to-back: `in_valid` held high with two consecutive results → exactly one idle-high cycle between the two frames, with no data corruption.
- Reset mid-frame: `rst` pulsed at cycle 20 of a data frame → `sout`=1 and `busy`=0 on the next edge. A subsequent frame is sent correctly from its start bit.
